psum_timestep_collector: RTL

Parametrised on-chip successor to the simulation-only dump of linear-layer partial sums. It captures packed multi-timestep Psum vectors from the systolic controller (o_PsumData/o_PsumValid/o_Psum_Finish) into a FIFO. It splits each vector into per-timestep lanes, saturates them to an output width, and streams them over a valid/ready interface toward the LIF/spike stage. It also reports completion, overflow and saturation statistics.

---
 rtl/psum_timestep_collector.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/psum_timestep_collector.sv
// psum_timestep_collector
// Captures packed multi-timestep partial-sum vectors into a FIFO, then
// streams them one lane (timestep) per beat over valid/ready. Each lane is
// saturated or wrapped to OUT_W. Also reports layer completion, dropped
// vectors and per-layer vector/clamp counts.
module psum_timestep_collector #(
  parameter int T_NUM  = 4,
  parameter int PSUM_W = 20,
  parameter int OUT_W  = 16,
  parameter int SAT_EN = 1,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16,
  parameter int TIDX_W = (T_NUM > 1) ? $clog2(T_NUM) : 1
) (
  input  logic                     s_clk,
  input  logic                     s_rst,
  input  logic [T_NUM*PSUM_W-1:0]  i_PsumData,
  input  logic                     i_PsumValid,
  input  logic                     i_Psum_Finish,
  output logic [OUT_W-1:0]         o_out_data,
  output logic [TIDX_W-1:0]        o_out_tidx,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic                     o_out_last,
  output logic                     o_done,
  output logic                     o_overflow,
  output logic [CNT_W-1:0]         o_vec_cnt,
  output logic [CNT_W-1:0]         o_sat_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int VW = T_NUM * PSUM_W;

  localparam logic [AW:0]        PTR_ONE   = 1;
  localparam logic [TIDX_W-1:0]  LANE_ONE  = 1;
  localparam logic [TIDX_W-1:0]  LAST_LANE = TIDX_W'(T_NUM - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = 1;
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  // Signed clamp limits expressed at lane width.
  localparam logic signed [PSUM_W-1:0] SAT_MAX =
    {{(PSUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PSUM_W-1:0] SAT_MIN =
    {{(PSUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                     state_q, state_d;
  logic [DEPTH-1:0][VW-1:0]   mem_q, mem_d;
  logic [AW:0]                wr_ptr_q, wr_ptr_d;
  logic [AW:0]                rd_ptr_q, rd_ptr_d;
  logic [AW:0]                wr_lag_q, wr_lag_d;
  logic [TIDX_W-1:0]          lane_q, lane_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUT_W-1:0]           out_data_q, out_data_d;
  logic [TIDX_W-1:0]          out_tidx_q, out_tidx_d;
  logic                       out_last_q, out_last_d;
  logic [CNT_W-1:0]           vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0]           sat_cnt_q, sat_cnt_d;
  logic                       ovf_q, ovf_d;

  logic                       full, empty, rd_empty;
  logic                       load, pop, wr_open, accept, drop, layer_start;
  logic [VW-1:0]              head;
  logic [T_NUM-1:0][OUT_W-1:0] lane_val;
  logic [T_NUM-1:0]           lane_clip;
  logic [CNT_W-1:0]           vec_base, sat_base;
  logic                       ovf_base;

  // FIFO status. The read side looks at a one-cycle-delayed write pointer,
  // which puts a fresh vector's first beat two edges after its write.
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign rd_empty = (wr_lag_q == rd_ptr_q);
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  // Output register reloads when empty or being consumed this cycle.
  assign load        = !rd_empty && (!out_valid_q || i_out_ready);
  assign pop         = load && (lane_q == LAST_LANE);
  assign wr_open     = (state_q == S_IDLE) || (state_q == S_RUN);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign accept      = i_PsumValid && wr_open && (!full || pop);
  assign drop        = i_PsumValid && !accept;
  assign layer_start = (state_q == S_IDLE) && i_PsumValid;

  // Per-lane extraction and saturate/wrap to the output width.
  for (genvar t = 0; t < T_NUM; t++) begin : g_lane
    logic signed [PSUM_W-1:0] raw;
    assign raw = head[t*PSUM_W +: PSUM_W];
    if (SAT_EN != 0) begin : g_sat
      logic hi, lo;
      assign hi           = raw > SAT_MAX;
      assign lo           = raw < SAT_MIN;
      assign lane_clip[t] = hi | lo;
      assign lane_val[t]  = hi ? SAT_MAX[OUT_W-1:0] :
                            (lo ? SAT_MIN[OUT_W-1:0] : raw[OUT_W-1:0]);
    end else begin : g_wrap
      assign lane_clip[t] = 1'b0;
      assign lane_val[t]  = raw[OUT_W-1:0];
    end
  end

  // Layer FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_PsumValid)        state_d = i_Psum_Finish ? S_DRAIN : S_RUN;
        else if (i_Psum_Finish) state_d = S_DRAIN;
      end
      S_RUN:   if (i_Psum_Finish) state_d = S_DRAIN;
      // Done once nothing is queued and the last beat leaves this cycle.
      S_DRAIN: if (empty && !out_valid_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage and pointer updates.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_lag_d = wr_ptr_q;
    if (accept) begin
      mem_d[wr_ptr_q[AW-1:0]] = i_PsumData;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Output beat register and lane walker; holds its beat while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tidx_d  = out_tidx_q;
    out_last_d  = out_last_q;
    lane_d      = lane_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_val[lane_q];
      out_tidx_d  = lane_q;
      out_last_d  = pop && (state_q == S_DRAIN) &&
                    ((rd_ptr_q + PTR_ONE) == wr_ptr_q);
      lane_d      = pop ? '0 : lane_q + LANE_ONE;
    end else if (i_out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // Per-layer statistics; a new layer clears them before counting.
  always_comb begin
    vec_base  = layer_start ? '0   : vec_cnt_q;
    sat_base  = layer_start ? '0   : sat_cnt_q;
    ovf_base  = layer_start ? 1'b0 : ovf_q;
    vec_cnt_d = vec_base;
    sat_cnt_d = sat_base;
    ovf_d     = ovf_base | drop;
    if (accept && (vec_base != CNT_MAX))
      vec_cnt_d = vec_base + CNT_ONE;
    if (load && lane_clip[lane_q] && (sat_base != CNT_MAX))
      sat_cnt_d = sat_base + CNT_ONE;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_lag_q    <= '0;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tidx_q  <= '0;
      out_last_q  <= 1'b0;
      vec_cnt_q   <= '0;
      sat_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_lag_q    <= wr_lag_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tidx_q  <= out_tidx_d;
      out_last_q  <= out_last_d;
      vec_cnt_q   <= vec_cnt_d;
      sat_cnt_q   <= sat_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // FIFO payload; contents are meaningless once the pointers reset.
  always_ff @(posedge s_clk) begin
    mem_q <= mem_d;
  end

  assign o_out_data  = out_data_q;
  assign o_out_tidx  = out_tidx_q;
  assign o_out_valid = out_valid_q;
  assign o_out_last  = out_last_q;
  assign o_done      = (state_q == S_DONE);
  assign o_overflow  = ovf_q;
  assign o_vec_cnt   = vec_cnt_q;
  assign o_sat_cnt   = sat_cnt_q;

endmodule
